// File: rtl/mem_arb_if.sv
// Memory-port arbiter bus: store/load client handshakes plus the tagged memory port.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        MEM_CMD_NONE  = 2'd0,
        MEM_CMD_LOAD  = 2'd1,
        MEM_CMD_STORE = 2'd2
    } mem_cmd_e;
endpackage

interface mem_arb_if;
    logic                   st_valid;
    logic [31:0]            st_addr;
    logic [63:0]            st_data;
    logic                   st_accept;
    logic                   ld_valid;
    logic [31:0]            ld_addr;
    logic                   ld_accept;
    logic                   ld_resp_valid;
    logic [31:0]            ld_resp_addr;
    logic [63:0]            ld_resp_data;
    mem_arb_pkg::mem_cmd_e  t_command;
    logic [31:0]            t_addr;
    logic [63:0]            t_data;
    logic [3:0]             r_response;
    logic [63:0]            r_data;
    logic [3:0]             r_tag;
    logic                   tag_err;

    // Arbiter side: drives the memory command port and the client responses.
    modport master (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  r_response, r_data, r_tag,
        output st_accept, ld_accept, ld_resp_valid, ld_resp_addr, ld_resp_data,
        output t_command, t_addr, t_data, tag_err
    );

    // Environment side: clients and memory.
    modport slave (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        output r_response, r_data, r_tag,
        input  st_accept, ld_accept, ld_resp_valid, ld_resp_addr, ld_resp_data,
        input  t_command, t_addr, t_data, tag_err
    );
endinterface

// File: rtl/mem_arb.sv
// Memory-port arbiter: merges victim-cache writebacks and dcache fills onto one
// tagged memory port and routes tagged fill returns back to the load client.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LD = 8,
    parameter int unsigned NTAG   = 16
) (
    input  logic      clock,
    input  logic      reset,
    mem_arb_if.master bus
);
    localparam int unsigned CNT_W  = $clog2(MAX_LD + 1);
    localparam int unsigned ADDR_W = 32;

    typedef enum logic {
        GRANT_LOAD  = 1'b0,
        GRANT_STORE = 1'b1
    } grant_e;

    grant_e            last_grant;
    grant_e            last_grant_nxt;
    logic [CNT_W-1:0]  ld_cnt;
    logic [CNT_W-1:0]  ld_cnt_nxt;
    logic [NTAG-1:0]   tbl_valid;
    logic [ADDR_W-1:0] tbl_addr [NTAG];

    logic ld_elig;
    logic accept;
    logic grant_st;
    logic grant_ld;
    logic st_acc;
    logic ld_acc;
    logic retire;
    logic tag_miss;
    logic alloc_live;
    logic cnt_inc;

    // Eligibility looks at the registered count, so a same-cycle retire cannot unblock.
    assign ld_elig = bus.ld_valid && (ld_cnt < CNT_W'(MAX_LD));
    assign accept  = bus.r_response != 4'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_LOAD;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Grant selection and command issue; ties alternate away from the last accepted client.
    always_comb begin
        grant_st       = 1'b0;
        grant_ld       = 1'b0;
        st_acc         = 1'b0;
        ld_acc         = 1'b0;
        last_grant_nxt = last_grant;
        bus.t_command  = MEM_CMD_NONE;
        bus.t_addr     = '0;
        bus.t_data     = '0;

        if (bus.st_valid && ld_elig) begin
            grant_st = (last_grant == GRANT_LOAD);
            grant_ld = (last_grant == GRANT_STORE);
        end else begin
            grant_st = bus.st_valid;
            grant_ld = ld_elig;
        end

        st_acc = grant_st && accept;
        ld_acc = grant_ld && accept;

        if (grant_st) begin
            bus.t_command = MEM_CMD_STORE;
            bus.t_addr    = bus.st_addr;
            bus.t_data    = bus.st_data;
        end else if (grant_ld) begin
            bus.t_command = MEM_CMD_LOAD;
            bus.t_addr    = bus.ld_addr;
        end

        if (st_acc) begin
            last_grant_nxt = GRANT_STORE;
        end else if (ld_acc) begin
            last_grant_nxt = GRANT_LOAD;
        end
    end

    assign bus.st_accept = st_acc;
    assign bus.ld_accept = ld_acc;

    // A same-tag retire frees the slot before the new load lands in it.
    assign retire     = (bus.r_tag != 4'd0) &&  tbl_valid[bus.r_tag];
    assign tag_miss   = (bus.r_tag != 4'd0) && !tbl_valid[bus.r_tag];
    assign alloc_live = tbl_valid[bus.r_response] &&
                        !(retire && (bus.r_tag == bus.r_response));
    assign cnt_inc    = ld_acc && !alloc_live;

    // Count tracks live table entries, so an overwritten tag does not inflate it.
    always_comb begin
        ld_cnt_nxt = ld_cnt;
        unique case ({cnt_inc, retire})
            2'b10:   ld_cnt_nxt = ld_cnt + CNT_W'(1);
            2'b01:   ld_cnt_nxt = ld_cnt - CNT_W'(1);
            default: ld_cnt_nxt = ld_cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_cnt            <= '0;
            tbl_valid         <= '0;
            bus.ld_resp_valid <= 1'b0;
            bus.ld_resp_addr  <= '0;
            bus.ld_resp_data  <= '0;
            bus.tag_err       <= 1'b0;
        end else begin
            ld_cnt            <= ld_cnt_nxt;
            bus.ld_resp_valid <= retire;
            if (retire) begin
                bus.ld_resp_addr        <= tbl_addr[bus.r_tag];
                bus.ld_resp_data        <= bus.r_data;
                tbl_valid[bus.r_tag]    <= 1'b0;
            end
            if (ld_acc) begin
                tbl_valid[bus.r_response] <= 1'b1;
            end
            if (tag_miss || (ld_acc && alloc_live)) begin
                bus.tag_err <= 1'b1;
            end
        end
    end

    // Address payload needs no reset; validity lives in tbl_valid.
    always_ff @(posedge clock) begin
        if (ld_acc) begin
            tbl_addr[bus.r_response] <= bus.ld_addr;
        end
    end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Memory-port arbiter directly downstream of the victim cache and the dcache miss path.
- Merges victim-cache writebacks (store client) and dcache line fills (load client) onto the single tagged memory port (t_command/t_addr/t_data, r_response/r_data/r_tag).
- Tracks outstanding load tags and routes returning fill data, with its address, back to the load client.
- Replaces direct drive of the memory port by the victim cache; the store client is the victim cache's writeback request.

Parameters:
- MAX_LD, 8, maximum outstanding loads in flight (1..15); loads stall when reached.
- NTAG, 16, memory tag space; tag 0 means "no response/none", usable tags 1..NTAG-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request (block writeback)
- st_addr  in  32  store byte address, bits [2:0] zero
- st_data  in  64  store block
- st_accept  out  1  store taken this cycle
- ld_valid  in  1  load request (line fill)
- ld_addr  in  32  load byte address, bits [2:0] zero
- ld_accept  out  1  load taken this cycle
- ld_resp_valid  out  1  fill data valid
- ld_resp_addr  out  32  address of returned fill
- ld_resp_data  out  64  returned block
- t_command  out  2  MEM_CMD_NONE/LOAD/STORE
- t_addr  out  32  memory address
- t_data  out  64  store data (0 when not storing)
- r_response  in  4  nonzero = command accepted, value = tag (loads)
- r_data  in  64  load return data
- r_tag  in  4  nonzero = r_data valid for that tag
- tag_err  out  1  sticky: r_tag returned with no matching outstanding entry

Behaviour:
- Reset (synchronous): tag table all invalid, ld_cnt=0, last_grant=LOAD (so the store wins the first tie), ld_resp_valid=0, ld_resp_addr=0, ld_resp_data=0, tag_err=0.
- Outputs with no active grant: t_command=MEM_CMD_NONE, t_addr=0, t_data=0, st_accept=0, ld_accept=0.
- Grant (combinational each cycle):
  - Load is eligible iff ld_valid && ld_cnt < MAX_LD.
  - Only store requesting: grant store. Only an eligible load requesting: grant load.
  - Both requesting: grant the one not in last_grant (alternate).
  - last_grant updates only on an accepted command.
- Issue:
  - Granted client drives t_command, t_addr and, for stores, t_data in the same cycle.
  - Accept is r_response != 0 in that cycle; st_accept/ld_accept = grant && accept, combinational.
  - No accept: the client must hold its request stable; the grant is re-evaluated next cycle with unchanged last_grant.
- Load tag allocation:
  - On ld_accept, table[r_response] <= {valid=1, addr=ld_addr}; ld_cnt increments.
  - r_response reusing a tag that is still valid (and not retiring this cycle) overwrites the entry and sets tag_err.
- Return path:
  - When r_tag != 0 and table[r_tag].valid: next cycle ld_resp_valid=1, ld_resp_addr=table[r_tag].addr, ld_resp_data=r_data. Entry is cleared; ld_cnt decrements. Latency is 1 cycle from r_tag.
  - ld_resp_valid is a one-cycle pulse; the load client must not backpressure.
  - r_tag != 0 with no valid entry: no response, tag_err <= 1 (sticky until reset).
- Simultaneous events:
  - Retire and allocate in the same cycle: ld_cnt unchanged.
  - Retire and allocate of the same tag in the same cycle: retire the old entry first (its data is returned), then install the new one; tag_err is not set.
  - Load eligibility uses the registered ld_cnt, so at ld_cnt==MAX_LD a same-cycle retire does not unblock the load until the next cycle.
- Stores:
  - No tag is tracked; a store is complete on st_accept.
  - A load to an address with an accepted store is ordered by memory; no forwarding is done here.
- Widths: ld_cnt is IDX_LEN(MAX_LD+1) bits and never exceeds MAX_LD or underflows.
- Reset mid-operation drops all outstanding tags; later r_tag returns for those tags set tag_err.

Test Plan:
- Store only: st_valid, st_addr=0x100, st_data=0xDEAD_BEEF_0000_0001, r_response=1 -> t_command=STORE, t_addr=0x100, t_data matches, st_accept=1 same cycle, ld_cnt stays 0.
- Load round trip: ld_addr=0x208, r_response=5; 3 cycles later r_tag=5, r_data=0x1234 -> next cycle ld_resp_valid=1, addr=0x208, data=0x1234; entry 5 cleared, ld_cnt=0.
- Contention: st_valid and ld_valid held for 4 cycles, r_response=2,3,4,5 -> grants STORE, LOAD, STORE, LOAD.
- Refusal: store requested with r_response=0 for 3 cycles, then 7 -> st_accept only in cycle 4; t_command=STORE stable all 4 cycles.
- Limit: MAX_LD=2, two loads accepted (tags 1,2), third ld_valid -> ld_accept=0 and t_command=NONE; r_tag=1 -> the third load issues the following cycle.
- Errors: r_tag=9 with no entry -> tag_err=1, no ld_resp_valid; same-cycle r_tag=3 (valid) and new load accepted on tag 3 -> old addr returned, new entry installed, tag_err stays 0.
